// File: rtl/hazard_ctrl.sv
// hazard_ctrl: MIPS pipeline hazard controller (load-use stall, branch squash, mul/div hold).
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
`default_nettype none

module hazard_ctrl #(
  parameter int MD_LATENCY  = 4,
  parameter int CNT_W       = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [4:0]             Rs_ID,
  input  logic [4:0]             Rt_ID,
  input  logic                   UsesRt_ID,
  input  logic                   MemRead_Ex,
  input  logic [4:0]             WReg_Ex,
  input  logic                   BranchTaken_Ex,
  input  logic                   MulDiv_Ex,
  output logic                   PCWrite,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Write,
  output logic                   ID_EX_Flush,
  output logic                   MD_Busy,
  output logic [STALL_CNT_W-1:0] StallCount
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  // Register 0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign load_use = MemRead_Ex && (WReg_Ex != 5'd0) &&
                    ((WReg_Ex == Rs_ID) || (UsesRt_ID && (WReg_Ex == Rt_ID)));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Write = 1'b1;
    ID_EX_Flush = 1'b0;
    MD_Busy     = 1'b0;
    case (state_q)
      RUN: begin
        if (BranchTaken_Ex) begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
        end else if (MulDiv_Ex) begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Write = 1'b0;
          state_d     = MD_BUSY;
          cnt_d       = MD_INIT;
        end else if (load_use) begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Flush = 1'b1;
        end
      end
      MD_BUSY: begin
        MD_Busy = 1'b1;
        // Cnt==1 is the release cycle: the front end moves again while the op finishes in EX.
        if (cnt_q > CNT_ONE) begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Write = 1'b0;
          cnt_d       = cnt_q - CNT_ONE;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= '0;
    end else if (!PCWrite && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign StallCount = stall_cnt_q;
`else
  assign StallCount = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table plus hand-written mul/div and reset sequences for hazard_ctrl.
`default_nettype none

module tb_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [4:0]  Rs_ID = '0, Rt_ID = '0, WReg_Ex = '0;
  logic        UsesRt_ID = 1'b0, MemRead_Ex = 1'b0, BranchTaken_Ex = 1'b0, MulDiv_Ex = 1'b0;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, MD_Busy;
  logic [15:0] StallCount;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4), .STALL_CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID),
    .MemRead_Ex(MemRead_Ex), .WReg_Ex(WReg_Ex), .BranchTaken_Ex(BranchTaken_Ex),
    .MulDiv_Ex(MulDiv_Ex), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
    .MD_Busy(MD_Busy), .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  // exp bits: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, MD_Busy}
  localparam logic [5:0] E_IDLE = 6'b110100;
  localparam logic [5:0] E_LU   = 6'b000110;
  localparam logic [5:0] E_BR   = 6'b111110;
  localparam logic [5:0] E_MDIN = 6'b000000;
  localparam logic [5:0] E_MDB  = 6'b000001;
  localparam logic [5:0] E_REL  = 6'b110101;

  typedef struct {
    logic [4:0] rs, rt, wreg;
    logic       usesrt, memrd, br, md;
    logic [5:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } sb_t;

  sb_t  sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic exp_pcw_last = 1'b1;
  logic [15:0] model_stall = '0;

  // Reference stall counter driven by the expected PCWrite of the cycle just checked.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) model_stall <= '0;
`ifdef HAZARD_STATS_EN
    else if (!exp_pcw_last && model_stall != 16'hFFFF) model_stall <= model_stall + 16'd1;
`endif
  end

  task automatic drive(input vec_t v);
    @(posedge Clk);
    #1;
    Rs_ID = v.rs; Rt_ID = v.rt; UsesRt_ID = v.usesrt; MemRead_Ex = v.memrd;
    WReg_Ex = v.wreg; BranchTaken_Ex = v.br; MulDiv_Ex = v.md;
    sb_q.push_back('{exp: v.exp, name: v.name});
  endtask

  task automatic check_out();
    sb_t        e;
    logic [5:0] got;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: queue empty, got nothing required one entry");
      return;
    end
    e   = sb_q.pop_front();
    got = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, MD_Busy};
    total++;
    if (got !== e.exp) begin
      bad++;
      $display("FAIL %s: got %b required %b", e.name, got, e.exp);
    end
    total++;
    if (StallCount !== model_stall) begin
      bad++;
      $display("FAIL %s_stallcnt: got %0d required %0d", e.name, StallCount, model_stall);
    end
    exp_pcw_last = e.exp[5];
  endtask

  task automatic step(input vec_t v);
    drive(v);
    @(negedge Clk);
    check_out();
  endtask

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic usesrt,
                              input logic memrd, input logic [4:0] wreg, input logic br,
                              input logic md, input logic [5:0] exp, input string name);
    vec_t v;
    v.rs = rs; v.rt = rt; v.usesrt = usesrt; v.memrd = memrd; v.wreg = wreg;
    v.br = br; v.md = md; v.exp = exp; v.name = name;
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    tbl[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE, "idle");
    tbl[1]  = mk(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, E_LU,   "lu_rs");
    tbl[2]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, E_IDLE, "lu_r0");
    tbl[3]  = mk(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, E_IDLE, "lu_rt_unused");
    tbl[4]  = mk(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, E_LU,   "lu_rt_used");
    tbl[5]  = mk(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, E_BR,   "br_over_lu");
    tbl[6]  = mk(5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, E_IDLE, "no_load");
    tbl[7]  = mk(5'd6, 5'd7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, E_IDLE, "lu_nomatch");
    tbl[8]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, E_BR,   "branch");
    tbl[9]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_BR,   "br_over_md");
    tbl[10] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE, "run_after_br_md");

    // Reset state, sampled while Rst is still held.
    repeat (2) @(posedge Clk);
    sb_q.push_back('{exp: E_IDLE, name: "reset"});
    @(negedge Clk);
    check_out();
    Rst = 1'b0;

    foreach (tbl[i]) step(tbl[i]);

    // Mul/div held in EX: branch and load-use arrive during MD_BUSY and must be ignored.
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, E_MDIN, "md_c1_entry"));
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_MDB,  "md_c2_br_ignored"));
    step(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, E_MDB,  "md_c3_lu_ignored"));
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_REL,  "md_c4_release"));
    // Back-to-back mul/div right after release.
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, E_MDIN, "md2_c1_entry"));
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_MDB,  "md2_c2"));
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_MDB,  "md2_c3"));
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_REL,  "md2_c4_release"));
    step(mk(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, E_LU,   "lu_after_md"));
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE, "idle_after_md"));

    // Asynchronous reset in MD_BUSY with Cnt==2 takes effect mid-cycle.
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, E_MDIN, "md3_c1_entry"));
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_MDB,  "md3_c2"));
    @(posedge Clk);
    #2;
    Rst = 1'b1;
    sb_q.push_back('{exp: E_IDLE, name: "rst_mid_md"});
    #1;
    check_out();
    #1;
    Rst = 1'b0;
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE, "idle_after_rst"));
    step(mk(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, E_LU,   "lu_after_rst"));
    step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE, "final_idle"));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, required finish before 20000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the MIPS datapath.
- Drives write-enable and flush controls of the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards, squashes wrong-path instructions on taken branches, and sequences multi-cycle mul/div ops by holding them in EX for MD_LATENCY cycles.
- Sits beside the ID stage; all inputs come from the ID and EX stage registers.

Parameters:
- MD_LATENCY, 4: total EX-occupancy cycles of a mul/div op; must be >= 2.
- CNT_W, 4: mul/div down-counter width; must hold MD_LATENCY-1.
- STALL_CNT_W, 16: width of the stall statistics counter (optional feature).

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Rs_ID  in  5  rs field of the instruction in ID.
- Rt_ID  in  5  rt field of the instruction in ID.
- UsesRt_ID  in  1  ID instruction reads rt as a source.
- MemRead_Ex  in  1  EX instruction is a load.
- WReg_Ex  in  5  destination register of the EX instruction.
- BranchTaken_Ex  in  1  branch in EX resolved taken.
- MulDiv_Ex  in  1  EX instruction is a mul/div.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register load enable.
- IF_ID_Flush  out  1  IF/ID clears to NOP at next edge.
- ID_EX_Write  out  1  ID/EX register load enable.
- ID_EX_Flush  out  1  ID/EX loads a bubble (all controls 0) at next edge.
- MD_Busy  out  1  mul/div sequencing in progress.
- StallCount  out  STALL_CNT_W  stall-cycle statistics (optional feature).

Behaviour:
- State register, two states: RUN, MD_BUSY.
- Counter Cnt, CNT_W bits.
- Outputs are combinational from state, Cnt and inputs.
- Default outputs (RUN, no event): PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, MD_Busy=0.
- Rst asserted: state=RUN, Cnt=0, StallCount=0, outputs at default. Takes effect immediately, including mid-MD_BUSY (op aborted, no release cycle).
- Priority in RUN: branch > mul/div > load-use.
- Branch, RUN and BranchTaken_Ex=1:
  - IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, IF_ID_Write=1.
  - State stays RUN.
  - Load-use and MulDiv_Ex are ignored in this cycle.
- Mul/div entry, RUN and MulDiv_Ex=1 and BranchTaken_Ex=0:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, flushes 0.
  - Next state MD_BUSY, Cnt<=MD_LATENCY-1.
- MD_BUSY:
  - MD_Busy=1. Cnt decrements every cycle.
  - Cnt>1: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0.
  - Cnt==1 (release cycle): default enables; next state RUN, Cnt<=0.
  - BranchTaken_Ex, MulDiv_Ex and load-use are ignored in all MD_BUSY cycles, including release.
  - Net effect: the op occupies EX exactly MD_LATENCY cycles; the front end is frozen MD_LATENCY-1 cycles.
- Load-use hazard:
  - Condition: RUN, no branch, no mul/div entry, MemRead_Ex=1, WReg_Ex!=0, and (WReg_Ex==Rs_ID or (UsesRt_ID and WReg_Ex==Rt_ID)).
  - Response: PCWrite=0, IF_ID_Write=0, ID_EX_Write=1, ID_EX_Flush=1.
  - Exactly one bubble per load; the next cycle re-evaluates with the new EX contents.
  - Register 0 never causes a hazard.
- Back-to-back: a mul/div arriving in EX the cycle after release re-enters MD_BUSY normally.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - StallCount increments by 1 on every clock edge where PCWrite==0 and Rst==0.
  - Saturates at all-ones.
  - Cleared by Rst.
- Undefined:
  - StallCount is tied to 0 and no counter flops are built.
  - Port list is unchanged.

Test Plan:
- Reset: Rst=1 mid-MD_BUSY (Cnt=2) -> same cycle state=RUN, MD_Busy=0, PCWrite=1, StallCount=0.
- Load-use on rs: MemRead_Ex=1, WReg_Ex=8, Rs_ID=8 -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for 1 cycle.
- Load-use false cases:
  - WReg_Ex=0 with Rs_ID=0 -> no stall.
  - WReg_Ex=9, Rt_ID=9, UsesRt_ID=0 -> no stall.
  - Same with UsesRt_ID=1 -> stall.
- Branch priority: BranchTaken_Ex=1 with a load-use match present -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, no stall.
- Mul/div, MD_LATENCY=4: MulDiv_Ex=1 held -> PCWrite=0 for exactly 3 cycles, MD_Busy=1 for cycles 2-4, release in cycle 4, no re-trigger; StallCount=3 with HAZARD_STATS_EN.
- Mul/div vs branch: MulDiv_Ex=1 and BranchTaken_Ex=1 together -> flush only, state stays RUN. BranchTaken_Ex=1 during MD_BUSY -> ignored, no flush.
